// File: rtl/mfp_ahb_cmd_master_if.sv
// Command/response port and AHB-Lite bus signals of the single-transfer command master.
interface mfp_ahb_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/mfp_ahb_cmd_master.sv
// AHB-Lite SINGLE-transfer initiator: valid/ready commands in, one-cycle response pulses out.
// Define MFP_AHB_MASTER_PIPELINE_EN to overlap the next address phase with the current data phase.
module mfp_ahb_cmd_master (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  mfp_ahb_cmd_master_if.master        bus
);

  logic        aph_valid;
  logic        aph_write;
  logic [31:0] aph_addr;
  logic [1:0]  aph_size;
  logic [31:0] aph_wdata;

  logic        dph_valid;
  logic        dph_write;
  logic [31:0] dph_wdata;

  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic        accept;
  logic        dph_done;
  logic [1:0]  size_norm;
  logic [31:0] addr_algn;

  always_comb begin
    size_norm = (bus.cmd_size == 2'd3) ? 2'd2 : bus.cmd_size;
    addr_algn = bus.cmd_addr;
    case (size_norm)
      2'd1:    addr_algn[0]   = 1'b0;
      2'd2:    addr_algn[1:0] = 2'b00;
      default: addr_algn      = bus.cmd_addr;
    endcase
  end

`ifdef MFP_AHB_MASTER_PIPELINE_EN
  // No new address phase may appear during the first cycle of an ERROR response.
  assign bus.cmd_ready = HRESETn & (~aph_valid | bus.HREADY) & ~(bus.HRESP & ~bus.HREADY);
`else
  assign bus.cmd_ready = HRESETn & ~(aph_valid | dph_valid);
`endif

  assign accept   = bus.cmd_valid & bus.cmd_ready;
  assign dph_done = dph_valid & bus.HREADY;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      aph_valid   <= 1'b0;
      aph_write   <= 1'b0;
      aph_addr    <= 32'h0;
      aph_size    <= 2'd0;
      aph_wdata   <= 32'h0;
      dph_valid   <= 1'b0;
      dph_write   <= 1'b0;
      dph_wdata   <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      if (accept) begin
        aph_valid <= 1'b1;
        aph_write <= bus.cmd_write;
        aph_addr  <= addr_algn;
        aph_size  <= size_norm;
        aph_wdata <= bus.cmd_wdata;
      end else if (aph_valid && bus.HREADY) begin
        aph_valid <= 1'b0;
      end

      // HREADY both retires the current data phase and admits the pending address phase.
      if (bus.HREADY) begin
        dph_valid <= aph_valid;
        dph_write <= aph_write;
        dph_wdata <= aph_wdata;
      end

      rsp_valid_q <= dph_done;
      rsp_err_q   <= dph_done & bus.HRESP;
      rsp_rdata_q <= (dph_done && !dph_write) ? bus.HRDATA : 32'h0;
    end
  end

  assign bus.HADDR     = aph_addr;
  assign bus.HTRANS    = aph_valid ? 2'b10 : 2'b00;
  assign bus.HWRITE    = aph_write;
  assign bus.HSIZE     = {1'b0, aph_size};
  assign bus.HBURST    = 3'b000;
  assign bus.HWDATA    = dph_valid ? dph_wdata : 32'h0;
  assign bus.busy      = aph_valid | dph_valid;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mfp_ahb_cmd_master.sv
// Directed bench for mfp_ahb_cmd_master; responses are checked by a scoreboard monitor.
module tb_mfp_ahb_cmd_master;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic HCLK;
  logic HRESETn;
  int   cyc;
  int   total;
  int   bad;
  exp_t sb[$];

  logic        mem_mode;
  logic [31:0] rdata_dir;
  logic [15:0] last_addr;

  mfp_ahb_cmd_master_if bus ();

  mfp_ahb_cmd_master dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.master)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // Tiny slave: in mem_mode a read returns 0xC0DE in the top half and the low address bits below.
  always @(posedge HCLK) if (bus.HTRANS == 2'b10 && bus.HREADY) last_addr <= bus.HADDR[15:0];
  assign bus.HRDATA = mem_mode ? {16'hC0DE, last_addr} : rdata_dir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Presents one command in the current cycle; returns in the address-phase cycle.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wdata, output int p);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_size  = size;
    bus.cmd_wdata = wdata;
    #1;
    chk("cmd_ready", 32'(bus.cmd_ready), 32'd1);
    p = cyc;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  always @(negedge HCLK) begin : monitor
    exp_t e;
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
  end

  initial begin
    int p;
    int pc[3];
    int n;
    int gap;
    total = 0;
    bad = 0;
    mem_mode = 1'b0;
    rdata_dir = 32'h0;
    HRESETn = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_size  = 2'd0;
    bus.cmd_wdata = 32'h0;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;

    // Reset state
    #2;
    chk("rst_htrans", 32'(bus.HTRANS), 32'd0);
    chk("rst_haddr", bus.HADDR, 32'h0);
    chk("rst_hwrite", 32'(bus.HWRITE), 32'd0);
    chk("rst_hsize", 32'(bus.HSIZE), 32'd0);
    chk("rst_hwdata", bus.HWDATA, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    repeat (2) @(posedge HCLK);
    #3;
    bus.cmd_valid = 1'b0;
    HRESETn = 1'b1;
    tick();

    // Word write, zero wait states
    issue(1'b1, 32'hBF80_0000, 2'd2, 32'h0000_00FF, p);
    sb.push_back('{32'h0, 1'b0, p + 3});
    chk("wr_htrans", 32'(bus.HTRANS), 32'd2);
    chk("wr_haddr", bus.HADDR, 32'hBF80_0000);
    chk("wr_hwrite", 32'(bus.HWRITE), 32'd1);
    chk("wr_hsize", 32'(bus.HSIZE), 32'd2);
    chk("wr_hburst", 32'(bus.HBURST), 32'd0);
    chk("wr_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("wr_hwdata", bus.HWDATA, 32'h0000_00FF);
    chk("wr_dph_htrans", 32'(bus.HTRANS), 32'd0);
    tick();
    chk("wr_done_busy", 32'(bus.busy), 32'd0);
    chk("wr_done_hwdata", bus.HWDATA, 32'h0);

    // Word read with two data-phase wait states
    issue(1'b0, 32'hBF80_0004, 2'd2, 32'h0, p);
    sb.push_back('{32'h0000_A5A5, 1'b0, p + 5});
    chk("rd_hwrite", 32'(bus.HWRITE), 32'd0);
    tick();
    bus.HREADY = 1'b0;
    rdata_dir = 32'h0000_A5A5;
    tick();
    chk("rd_wait_busy", 32'(bus.busy), 32'd1);
    tick();
    bus.HREADY = 1'b1;
    tick();
    tick();
    rdata_dir = 32'h0;

    // Alignment: halfword read, byte write, size 3 treated as word
    issue(1'b0, 32'h0000_0103, 2'd1, 32'h0, p);
    sb.push_back('{32'h5A5A_0000, 1'b0, p + 3});
    chk("hw_haddr", bus.HADDR, 32'h0000_0102);
    chk("hw_hsize", 32'(bus.HSIZE), 32'd1);
    tick();
    rdata_dir = 32'h5A5A_0000;
    tick();
    rdata_dir = 32'h0;
    issue(1'b1, 32'h0000_0103, 2'd0, 32'h3300_0000, p);
    sb.push_back('{32'h0, 1'b0, p + 3});
    chk("b_haddr", bus.HADDR, 32'h0000_0103);
    chk("b_hsize", 32'(bus.HSIZE), 32'd0);
    tick();
    tick();
    issue(1'b0, 32'h0000_0107, 2'd3, 32'h0, p);
    sb.push_back('{32'h0, 1'b0, p + 3});
    chk("s3_haddr", bus.HADDR, 32'h0000_0104);
    chk("s3_hsize", 32'(bus.HSIZE), 32'd2);
    tick();
    tick();

    // Two-cycle ERROR on a write
    issue(1'b1, 32'h1FC0_0000, 2'd2, 32'hDEAD_BEEF, p);
    sb.push_back('{32'h0, 1'b1, p + 4});
    tick();
    bus.HRESP = 1'b1;
    bus.HREADY = 1'b0;
    #1;
    chk("err1_hwdata", bus.HWDATA, 32'hDEAD_BEEF);
    chk("err1_htrans", 32'(bus.HTRANS), 32'd0);
    tick();
    bus.HREADY = 1'b1;
    #1;
    chk("err2_hwdata", bus.HWDATA, 32'hDEAD_BEEF);
    chk("err2_htrans", 32'(bus.HTRANS), 32'd0);
    chk("err2_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    bus.HRESP = 1'b0;
    tick();

    // Three back-to-back reads with cmd_valid held high
    mem_mode = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_size  = 2'd2;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_addr = 32'(i * 4);
      #1;
      n = 0;
      while (!bus.cmd_ready && n < 10) begin
        tick();
        #1;
        n++;
      end
      chk("b2b_ready", 32'(bus.cmd_ready), 32'd1);
      pc[i] = cyc;
      sb.push_back('{32'hC0DE_0000 | 32'(i * 4), 1'b0, pc[i] + 3});
      tick();
      chk("b2b_htrans", 32'(bus.HTRANS), 32'd2);
      chk("b2b_haddr", bus.HADDR, 32'(i * 4));
    end
    bus.cmd_valid = 1'b0;
`ifdef MFP_AHB_MASTER_PIPELINE_EN
    gap = 1;
`else
    gap = 3;
`endif
    chk("b2b_gap01", pc[1] - pc[0], gap);
    chk("b2b_gap12", pc[2] - pc[1], gap);
    repeat (5) tick();

    // Reset during a stalled data phase drops the transfer
    issue(1'b1, 32'h0000_0020, 2'd2, 32'h1234_5678, p);
    tick();
    bus.HREADY = 1'b0;
    #1;
    HRESETn = 1'b0;
    #1;
    chk("mrst_htrans", 32'(bus.HTRANS), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_hwdata", bus.HWDATA, 32'h0);
    chk("mrst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    chk("mrst_busy2", 32'(bus.busy), 32'd0);
    chk("mrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    HRESETn = 1'b1;
    bus.HREADY = 1'b1;
    repeat (3) tick();
    issue(1'b0, 32'h0000_0010, 2'd2, 32'h0, p);
    sb.push_back('{32'hC0DE_0010, 1'b0, p + 3});
    tick();

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("sb_drain", sb.size(), 32'd0);
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mfp_ahb_cmd_master.md
# mfp_ahb_cmd_master

AHB-Lite initiator that turns single-word commands from a simple valid/ready port into AHB-Lite SINGLE transfers and returns read data and error status. It drives the same system bus that the memory-mapped peripherals (GPIO, timers, display) respond on. Its intended clients are test benches, debug bridges and small hardware sequencers that need bus access without a CPU. Supports wait states, two-cycle ERROR responses and, optionally, address/data phase overlap.

## Interface
Parameters: none. Widths are fixed at 32-bit address and data.

Ports:
- HCLK  in  1  bus clock; all logic is rising-edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted on a cycle with cmd_valid&cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- cmd_wdata  in  32  write data, already lane-aligned by the caller.
- rsp_valid  out  1  one-cycle pulse: transfer complete. No backpressure.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_err  out  1  transfer ended with HRESP=ERROR.
- busy  out  1  an address or data phase is outstanding.
- HADDR  out  32  bus address.
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- HWRITE  out  1  bus direction.
- HSIZE  out  3  {1'b0, size}.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HWDATA  out  32  write data, driven during the data phase.
- HRDATA  in  32  read data.
- HREADY  in  1  transfer-phase completion.
- HRESP  in  1  0 = OKAY, 1 = ERROR.

## Operation
State is held in two registered slots.
- Address slot (aph): drives HADDR, HTRANS, HWRITE and HSIZE.
- Data slot (dph): holds write/valid/wdata for the transfer currently in its data phase.

Command path:
- A command accepted at edge E is loaded into aph and appears on the bus in the cycle after E, with HTRANS=NONSEQ.
- Address alignment: HADDR is cmd_addr with the low bits forced to zero per size. Word clears [1:0]; halfword clears [0]; byte is unmodified.

Phase advance:
- When HTRANS=NONSEQ and HREADY=1, aph moves into dph at the edge.
- aph then becomes IDLE, unless a new command is accepted on the same edge.

Data phase:
- HWDATA = dph.wdata while dph is valid; 0 otherwise.
- When dph is valid and HREADY=1, the transfer completes.
- At the next edge, rsp_valid is set for one cycle. rsp_rdata is set to HRDATA for a read, 0 for a write. rsp_err is set to the HRESP sampled at that completion cycle.

Error handling:
- An ERROR response spans two cycles: HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1.
- During the first cycle, the master holds all outputs.
- A pipelined address phase that is already on the bus is not cancelled and completes normally.

busy = aph valid | dph valid.

## Timing
Reset:
- HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0.
- rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
- cmd_ready=0 while HRESETn is low.

Reset mid-operation: all slots clear immediately and the bus goes IDLE. The outstanding transfer is dropped with no response.

Latency with zero wait states:
- Accept at edge E0.
- Address phase in cycle 1.
- Data phase in cycle 2.
- rsp_valid in cycle 3.

Each HREADY=0 cycle adds one cycle to the phase it stalls. No timeout.

cmd_ready is combinational from HREADY. A caller must not make cmd_valid depend combinationally on cmd_ready.

## Configuration
Macro: MFP_AHB_MASTER_PIPELINE_EN.
- Defined: cmd_ready = ~aph.valid | HREADY. The next address phase overlaps the current data phase, giving one transfer per cycle with zero waits.
- Undefined: cmd_ready = ~busy. Transfers are strictly serialized, one per 3 cycles with zero waits, and HTRANS returns to IDLE between transfers.

## Test plan
- Word write of 0x000000FF to 0xBF800000, HREADY=1:
  - Cycle 1: HTRANS=10, HADDR=0xBF800000, HWRITE=1, HSIZE=010.
  - Cycle 2: HWDATA=0xFF.
  - Cycle 3: rsp_valid=1, rsp_err=0.
- Word read of 0xBF800004 with HRDATA=0x0000A5A5 and HREADY low for 2 data-phase cycles: rsp_valid arrives in cycle 5 with rsp_rdata=0x0000A5A5 and rsp_err=0.
- Halfword read of 0x00000103: HADDR=0x00000102 and HSIZE=001. Byte write of 0x00000103: HADDR=0x00000103.
- ERROR response on a write to 0x1FC00000, driven as (HRESP=1, HREADY=0) then (1, 1): outputs are held in the first cycle, then a single rsp_valid pulse with rsp_err=1.
- Three back-to-back reads to 0x0, 0x4 and 0x8 with cmd_valid held high:
  - PIPELINE_EN defined: HTRANS=10 for 3 consecutive cycles and 3 consecutive rsp_valid pulses.
  - PIPELINE_EN undefined: NONSEQ cycles are 3 cycles apart.
- HRESETn pulsed low during a data phase with HREADY=0: HTRANS=00 and busy=0 during reset, no rsp_valid, and a fresh command after release completes normally.
